hilo_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle HI/LO multiply/divide unit for the integer pipeline.

---
 rtl/hilo_muldiv_pkg.sv | 34 +++
 rtl/hilo_muldiv_if.sv | 32 +++
 rtl/hilo_muldiv_unit_divider.sv | 131 +++++++++++++
 rtl/hilo_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state types and a small operand-signedness helper.
package hilo_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_MUL  = 2'd1,
        TOP_DIV  = 2'd2
    } top_state_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_PREP = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } div_state_e;

    // Only MULTU treats its operands as unsigned; MADD/MSUB are signed.
    function automatic logic mul_is_signed(input op_e op);
        return (op != OP_MULTU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    // Handshake: an op is accepted on a rising edge where start=1, cancel=0 and
    // busy=0; busy then stays high until the result edge, and done pulses for
    // exactly the one cycle in which HI/LO first show the new result.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_din;
    logic [WIDTH-1:0] b_din;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    top_state_e       dbg_state;
    div_state_e       dbg_div_state;

    modport master (
        output start, op, a_din, b_din, cancel,
        input  busy, done, hi_out, lo_out, dbg_state, dbg_div_state
    );

    modport slave (
        input  start, op, a_din, b_din, cancel,
        output busy, done, hi_out, lo_out, dbg_state, dbg_div_state
    );

endinterface

// File: rtl/hilo_muldiv_unit_divider.sv
// Restoring radix-2 divider on operand magnitudes: one PREP cycle, WIDTH
// iteration cycles, then a FIX cycle in which the signed results are valid.
module hilo_divider
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output div_state_e       state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div0_q, div0_d;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div0_d    = div0_q;
        neg_a     = signed_q & q_q[WIDTH-1];
        neg_b     = signed_q & b_q[WIDTH-1];
        rem_shift = {rem_q, q_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_q};

        if (cancel) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        q_d      = a;
                        b_d      = b;
                        signed_d = signed_mode;
                        state_d  = DIV_PREP;
                    end
                end
                DIV_PREP: begin
                    // A zero divisor keeps the raw dividend so it can be returned as HI.
                    div0_d  = (b_q == '0);
                    q_d     = (neg_a && (b_q != '0)) ? -q_q : q_q;
                    b_d     = neg_b ? -b_q : b_q;
                    rem_d   = '0;
                    q_neg_d = neg_a ^ neg_b;
                    r_neg_d = neg_a;
                    cnt_d   = CW'(WIDTH);
                    state_d = DIV_ITER;
                end
                DIV_ITER: begin
                    if (!div0_q) begin
                        if (!diff[WIDTH]) begin
                            rem_d = diff[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = rem_shift[WIDTH-1:0];
                            q_d   = {q_q[WIDTH-2:0], 1'b0};
                        end
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            q_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            div0_q   <= div0_d;
        end
    end

    assign busy      = (state_q != DIV_IDLE);
    assign done      = (state_q == DIV_FIX);
    assign quotient  = div0_q ? '1  : (q_neg_q ? -q_q : q_q);
    assign remainder = div0_q ? q_q : (r_neg_q ? -rem_q : rem_q);
    assign state_dbg = state_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: MUL_LAT-stage multiplier pipeline, iterative
// divider, MTHI/MTLO moves and multiply-accumulate/subtract writeback.
module hilo_muldiv_unit
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    top_state_e        state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    op_e               mul_op_q, mul_op_d;
    logic [MUL_LAT-1:0] mul_vld_q, mul_vld_d;
    logic [PW-1:0]     mul_pipe_q [MUL_LAT];
    logic [PW-1:0]     mul_pipe_d [MUL_LAT];

    op_e               op_in;
    logic              accept;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [WIDTH-1:0]  div_quot;
    logic [WIDTH-1:0]  div_rem;
    div_state_e        div_state;
    logic              mul_signed;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     product;
    logic [PW-1:0]     hilo_cur;
    logic [PW-1:0]     mul_result;

    assign op_in     = op_e'(bus.op);
    assign accept    = (state_q == TOP_IDLE) && bus.start && !bus.cancel && !div_busy;
    assign div_start = accept && ((op_in == OP_DIV) || (op_in == OP_DIVU));

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both modes.
    assign mul_signed = mul_is_signed(op_in);
    assign a_ext      = {{WIDTH{mul_signed & bus.a_din[WIDTH-1]}}, bus.a_din};
    assign b_ext      = {{WIDTH{mul_signed & bus.b_din[WIDTH-1]}}, bus.b_din};
    assign product    = a_ext * b_ext;
    assign hilo_cur   = {hi_q, lo_q};

    always_comb begin
        case (mul_op_q)
            OP_MADD: mul_result = hilo_cur + mul_pipe_q[MUL_LAT-1];
            OP_MSUB: mul_result = hilo_cur - mul_pipe_q[MUL_LAT-1];
            default: mul_result = mul_pipe_q[MUL_LAT-1];
        endcase
    end

    hilo_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_mode(op_in == OP_DIV),
        .a          (bus.a_din),
        .b          (bus.b_din),
        .cancel     (bus.cancel),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quot),
        .remainder  (div_rem),
        .state_dbg  (div_state)
    );

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        done_d         = 1'b0;
        mul_op_d       = mul_op_q;
        mul_vld_d[0]   = 1'b0;
        mul_pipe_d[0]  = mul_pipe_q[0];
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end

        case (state_q)
            TOP_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_MTHI: hi_d = bus.a_din;
                        OP_MTLO: lo_d = bus.a_din;
                        OP_DIV, OP_DIVU: state_d = TOP_DIV;
                        default: begin
                            state_d       = TOP_MUL;
                            mul_op_d      = op_in;
                            mul_vld_d[0]  = 1'b1;
                            mul_pipe_d[0] = product;
                        end
                    endcase
                end
            end
            TOP_MUL: begin
                if (bus.cancel) begin
                    state_d   = TOP_IDLE;
                    mul_vld_d = '0;
                end else if (mul_vld_q[MUL_LAT-1]) begin
                    {hi_d, lo_d} = mul_result;
                    done_d       = 1'b1;
                    state_d      = TOP_IDLE;
                end
            end
            TOP_DIV: begin
                if (bus.cancel) begin
                    state_d = TOP_IDLE;
                end else if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                    done_d  = 1'b1;
                    state_d = TOP_IDLE;
                end
            end
            default: begin
                state_d = TOP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TOP_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            mul_op_q  <= OP_MULT;
            mul_vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            mul_op_q  <= mul_op_d;
            mul_vld_q <= mul_vld_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe_q[i] <= mul_pipe_d[i];
            end
        end
    end

    assign bus.busy          = (state_q != TOP_IDLE);
    assign bus.done          = done_q;
    assign bus.hi_out        = hi_q;
    assign bus.lo_out        = lo_q;
    assign bus.dbg_state     = state_q;
    assign bus.dbg_div_state = div_state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32, MUL_LAT=3) with hand-computed results.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    hilo_muldiv_if #(.WIDTH(W)) bus();

    hilo_muldiv_unit #(.WIDTH(W), .MUL_LAT(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a_din  = '0;
        bus.b_din  = '0;
        bus.cancel = 1'b0;
    endtask

    // Called 1ns after an edge; the next rising edge is the accepting edge.
    task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_din = a;
        bus.b_din = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_din = ~a;
        bus.b_din = ~b;
    endtask

    // Counts edges until done is seen; n = -1 when the budget runs out.
    task automatic wait_done(input int max, output int n);
        n = 0;
        while (n < max && bus.done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.done !== 1'b1) n = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.hi_out, 32'h0); end
        checks++; if (bus.lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.lo_out, 32'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int n;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", bus.busy); end
        wait_done(10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL mult_latency: got %0d expected 3", n); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", bus.busy); end
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", bus.hi_out, 32'hFFFFFFFF); end
        checks++; if (bus.lo_out !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFEB); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_multu();
        int n;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_done(10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL multu_latency: got %0d expected 3", n); end
        checks++; if (bus.hi_out !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected %h", bus.hi_out, 32'h1); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFE); end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int n;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(40, n);
        checks++; if (n !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", n); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFD); end
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", bus.hi_out, 32'hFFFFFFFF); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_boundaries();
        int n;
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(40, n);
        checks++; if (n !== 34) begin errors++; $display("FAIL divu0_latency: got %0d expected 34", n); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFF); end
        checks++; if (bus.hi_out !== 32'h7) begin errors++; $display("FAIL divu0_hi: got %h expected %h", bus.hi_out, 32'h7); end
        @(posedge clk); #1;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(40, n);
        checks++; if (bus.lo_out !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", bus.lo_out, 32'h80000000); end
        checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected %h", bus.hi_out, 32'h0); end
        @(posedge clk); #1;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(40, n);
        checks++; if (bus.lo_out !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", bus.lo_out, 32'd14); end
        checks++; if (bus.hi_out !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected %h", bus.hi_out, 32'd2); end
        @(posedge clk); #1;
    endtask

    task automatic test_madd_msub();
        int n;
        issue(OP_MTHI, 32'h1234, 32'h0);
        checks++; if (bus.hi_out !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h expected %h", bus.hi_out, 32'h1234); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
        checks++; if (bus.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFF); end
        issue(OP_MADD, 32'd2, 32'd3);
        wait_done(10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL madd_latency: got %0d expected 3", n); end
        checks++; if (bus.hi_out !== 32'h1235) begin errors++; $display("FAIL madd_hi: got %h expected %h", bus.hi_out, 32'h1235); end
        checks++; if (bus.lo_out !== 32'h5) begin errors++; $display("FAIL madd_lo: got %h expected %h", bus.lo_out, 32'h5); end
        @(posedge clk); #1;
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'h0, 32'h0);
        issue(OP_MSUB, 32'd1, 32'd1);
        wait_done(10, n);
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub_hi: got %h expected %h", bus.hi_out, 32'hFFFFFFFF); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFF); end
        @(posedge clk); #1;
    endtask

    task automatic test_cancel();
        int n;
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", bus.busy); end
        wait_done(40, n);
        checks++; if (n !== -1) begin errors++; $display("FAIL cancel_no_done: got done after %0d edges expected none", n); end
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL cancel_hi: got %h expected %h", bus.hi_out, 32'hFFFFFFFF); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL cancel_lo: got %h expected %h", bus.lo_out, 32'hFFFFFFFF); end
        // start together with cancel while idle must be dropped
        bus.cancel = 1'b1;
        issue(OP_MTHI, 32'hABCD, 32'h0);
        bus.cancel = 1'b0;
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL start_cancel_hi: got %h expected %h", bus.hi_out, 32'hFFFFFFFF); end
    endtask

    task automatic test_start_busy();
        int n;
        issue(OP_MULTU, 32'd2, 32'd3);
        issue(OP_MULTU, 32'd9, 32'd9);
        wait_done(10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL busy_first_latency: got %0d expected 2", n); end
        checks++; if (bus.lo_out !== 32'd6) begin errors++; $display("FAIL busy_first_lo: got %h expected %h", bus.lo_out, 32'd6); end
        @(posedge clk); #1;
        wait_done(8, n);
        checks++; if (n !== -1) begin errors++; $display("FAIL busy_ignored_done: got done after %0d edges expected none", n); end
        checks++; if (bus.lo_out !== 32'd6) begin errors++; $display("FAIL busy_ignored_lo: got %h expected %h", bus.lo_out, 32'd6); end
    endtask

    task automatic test_back_to_back();
        int n;
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd21);
        issue(OP_MULTU, 32'd5, 32'd5);
        wait_done(10, n);
        checks++; if (bus.lo_out !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", bus.lo_out, 32'd25); end
        issue(OP_MULTU, 32'd7, 32'd3);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b expected 1", bus.busy); end
        wait_done(10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", n); end
        checks++; if (bus.lo_out !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_second_lo: got %h expected %h", bus.lo_out, 32'd21); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int n;
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstdiv_done: got %b expected 0", bus.done); end
        checks++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin errors++; $display("FAIL rstdiv_hilo: got %h %h expected 0 0", bus.hi_out, bus.lo_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done(40, n);
        checks++; if (n !== -1) begin errors++; $display("FAIL rstdiv_no_done: got done after %0d edges expected none", n); end
        issue(OP_MULT, 32'd3, 32'd4);
        wait_done(10, n);
        checks++; if (bus.lo_out !== 32'd12) begin errors++; $display("FAIL rstdiv_after_lo: got %h expected %h", bus.lo_out, 32'd12); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_boundaries();
        test_madd_msub();
        test_cancel();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
